line_frame_sequencer: RTL
=========================

Name: line_frame_sequencer

Overview:
- Frame-level initiator that drives the per-line enable of the 12-bit pixel/line counter and consumes that counter's end-of-line flag.
- Sequences a full frame: waits for downstream ready, enables one line, detects end of line, inserts a blanking gap, advances the line index, and flags end of frame.
- Supports the same normal/test split as the line counter: full line count in normal mode, reduced count in test mode.

Parameters:
- LINE_W, 12, width of line index.
- NUM_LINES, 4096, lines per frame in normal mode (1..2^LINE_W).
- NUM_LINES_TEST, 1290, lines per frame in test mode (1..2^LINE_W).
- GAP_CYCLES, 4, blanking cycles between lines (0..255); 0 = no gap state.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  frame start request, sampled in IDLE only.
- abort  input  1  synchronous abort, any state -> IDLE.
- test  input  1  1 = test mode, 0 = normal mode; latched at frame start.
- sink_ready  input  1  downstream can accept a new line.
- end_line  input  1  end-of-line flag from line counter.
- line_enb  output  1  enable to line counter, active high.
- line_idx  output  LINE_W  index of current/next line (0-based).
- start_of_line  output  1  one-cycle pulse, first cycle of each line.
- frame_busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse after last line completes.
- seq_err  output  1  sticky: end_line seen outside LINE state.

Behaviour:
- Reset: state IDLE, test_q 0, gap counter 0; line_enb 0, line_idx 0, start_of_line 0, frame_busy 0, frame_done 0, seq_err 0.
- All outputs registered; line_enb is 1 exactly in cycles where state == LINE.
- States: IDLE, WAIT_RDY, LINE, GAP, DONE.
- IDLE: start=1 -> WAIT_RDY; test_q <= test, line_idx <= 0, seq_err <= 0.
- WAIT_RDY: sink_ready=1 -> LINE; start_of_line=1 in the first LINE cycle. sink_ready=0 -> stay, line_enb stays 0.
- LINE: end_line=1 at an edge -> leave LINE; line_enb is 0 the next cycle, which clears the line counter.
  - If line_idx == last -> DONE; line_idx holds.
  - Otherwise line_idx += 1 and go to GAP (GAP_CYCLES>0) or WAIT_RDY (GAP_CYCLES==0).
- Last line: last = test_q ? NUM_LINES_TEST-1 : NUM_LINES-1.
- Minimum LINE duration is 1 cycle; end_line in the first LINE cycle is legal.
- GAP: counter loads GAP_CYCLES-1 on entry and decrements; at 0 -> WAIT_RDY. GAP occupies exactly GAP_CYCLES cycles.
- DONE: frame_done=1 for exactly this one cycle, then IDLE. line_idx holds last value until next start.
- start outside IDLE is ignored. test changes mid-frame are ignored (test_q is used).
- abort=1 has priority over all transitions: next state IDLE, line_enb 0 next cycle, no frame_done, line_idx holds.
- abort and start in the same IDLE cycle -> stay IDLE.
- seq_err: set when end_line=1 while state != LINE; stays set until next accepted start. Never changes the state flow.
- line_idx never wraps: increment only when line_idx < last.
- rst_n low at any time: immediate return to reset values, mid-line included.

Test Plan:
- Bench params NUM_LINES=4, NUM_LINES_TEST=2, GAP_CYCLES=3, sink_ready=1, end_line model fires after 5 enabled cycles. start pulse, test=0 -> 4 start_of_line pulses with line_idx 0,1,2,3; line_enb high 5 cycles per line; 3 low gap cycles between lines; one frame_done; frame_busy falls the cycle after frame_done.
- Same stimulus with test=1 at start, then test toggled mid-frame -> exactly 2 lines (idx 0,1), then frame_done.
- sink_ready held 0 for 10 cycles after each gap -> line_enb stays 0 those 10 cycles; line starts the cycle after ready rises; line count unchanged.
- abort asserted during line 2 -> line_enb 0 next cycle, state IDLE, no frame_done, line_idx=2 held; a new start restarts from line_idx 0.
- end_line pulsed while IDLE and while in GAP -> seq_err=1 and stays set; FSM timing unaffected; next start clears seq_err.
- rst_n asserted mid-LINE -> all outputs 0 asynchronously. start during busy -> ignored (no restart, line_idx sequence continues). GAP_CYCLES=0 -> next line_enb rises 2 cycles after end_line (WAIT_RDY, then LINE).

Source files
------------

// File: rtl/line_frame_sequencer.sv
// Frame-level initiator for the pixel/line counter: gates one line at a time,
// waits for downstream ready, inserts blanking gaps and flags end of frame.
module line_frame_sequencer #(
  parameter int LINE_W         = 12,
  parameter int NUM_LINES      = 4096,
  parameter int NUM_LINES_TEST = 1290,
  parameter int GAP_CYCLES     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              test,
  input  logic              sink_ready,
  input  logic              end_line,
  output logic              line_enb,
  output logic [LINE_W-1:0] line_idx,
  output logic              start_of_line,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              seq_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_LINE,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [LINE_W-1:0] LAST_NORM = LINE_W'(NUM_LINES - 1);
  localparam logic [LINE_W-1:0] LAST_TEST = LINE_W'(NUM_LINES_TEST - 1);
  localparam bit                HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [7:0]        GAP_LOAD  = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_e              state_q, state_d;
  logic                test_q, test_d;
  logic [LINE_W-1:0]   idx_q, idx_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic                seq_err_q, seq_err_d;
  logic                line_enb_q, line_enb_d;
  logic                sol_q, sol_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [LINE_W-1:0]   last_idx;
  logic                is_last;
  logic                accept_start;

  // The mode is frozen at frame start so a mid-frame toggle of test is ignored.
  assign last_idx     = test_q ? LAST_TEST : LAST_NORM;
  assign is_last      = (idx_q >= last_idx);
  assign accept_start = (state_q == S_IDLE) && start && !abort;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:     if (start)      state_d = S_WAIT_RDY;
        S_WAIT_RDY: if (sink_ready) state_d = S_LINE;
        S_LINE: begin
          if (end_line) begin
            if (is_last)      state_d = S_DONE;
            else if (HAS_GAP) state_d = S_GAP;
            else              state_d = S_WAIT_RDY;
          end
        end
        S_GAP:      if (gap_cnt_q == 8'd0) state_d = S_WAIT_RDY;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; every output is a flop driven from state_d.
  always_comb begin
    test_d    = test_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    seq_err_d = seq_err_q;

    if (accept_start) begin
      test_d    = test;
      idx_d     = '0;
      seq_err_d = 1'b0;
    end

    if ((state_q == S_LINE) && end_line && !abort && !is_last) begin
      idx_d = idx_q + LINE_W'(1);
    end

    if ((state_q == S_LINE) && (state_d == S_GAP)) begin
      gap_cnt_d = GAP_LOAD;
    end else if ((state_q == S_GAP) && (gap_cnt_q != 8'd0)) begin
      gap_cnt_d = gap_cnt_q - 8'd1;
    end

    // A stray end_line is recorded but never alters the state flow.
    if (end_line && (state_q != S_LINE)) begin
      seq_err_d = 1'b1;
    end

    line_enb_d = (state_d == S_LINE);
    sol_d      = (state_q == S_WAIT_RDY) && (state_d == S_LINE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_q     <= 1'b0;
      idx_q      <= '0;
      gap_cnt_q  <= 8'd0;
      seq_err_q  <= 1'b0;
      line_enb_q <= 1'b0;
      sol_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      test_q     <= test_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      seq_err_q  <= seq_err_d;
      line_enb_q <= line_enb_d;
      sol_q      <= sol_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign line_enb      = line_enb_q;
  assign line_idx      = idx_q;
  assign start_of_line = sol_q;
  assign frame_busy    = busy_q;
  assign frame_done    = done_q;
  assign seq_err       = seq_err_q;

endmodule
